// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared segment type, blank pattern and hex-to-segment lookup table
package seg_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_if: value producer side and display pin side of the scan controller
interface seg_scan_if #(parameter int NDIG = 4);
  import seg_pkg::*;
  logic [4*NDIG-1:0] value;
  logic load;
  logic lz_blank;
  seg_t seg;
  logic [NDIG-1:0] dig_en;
  logic pending;
  logic frame_done;
  modport master(output value, load, lz_blank, input seg, dig_en, pending, frame_done);
  modport slave(input value, load, lz_blank, output seg, dig_en, pending, frame_done);
endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// seg_decode: combinational hex nibble to seven-segment pattern
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = SEG_LUT[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan with slot blanking and frame-aligned double buffering
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input logic clk,
  input logic rst_n,
  seg_scan_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NDIG-1:0] shadow, pend_reg;
  logic pend;
  logic last_slot, boundary, vis;
  logic [NDIG:0] zero_above;
  logic [3:0] nib;
  seg_t dec;
  assign last_slot = cnt == CW'(DIV - 1);
  assign boundary = last_slot && idx == IW'(NDIG - 1);
  assign nib = shadow[4*idx +: 4];
  // zero_above[k] is set when nibbles k..NDIG-1 of the displayed value are all zero
  always_comb begin
    zero_above = '0;
    zero_above[NDIG] = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) zero_above[k] = zero_above[k+1] && shadow[4*k +: 4] == 4'd0;
  end
  seg_decode u_dec (.nib(nib), .seg(dec));
  // current digit is driven only past the blanking interval and when not a suppressed leading zero
  always_comb begin
    vis = cnt >= CW'(BLANK) && !(bus.lz_blank && idx != '0 && zero_above[idx]);
    bus.dig_en = vis ? NDIG'(1) << idx : '0;
    bus.seg = vis ? dec : SEG_BLANK;
  end
  assign bus.pending = pend;
  assign bus.frame_done = boundary;
  // slot/digit scan counters and the load buffer that swaps in only at the frame boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
      pend_reg <= '0;
      pend <= 1'b0;
    end else begin
      cnt <= last_slot ? '0 : cnt + CW'(1);
      if (last_slot) idx <= boundary ? '0 : idx + IW'(1);
      if (boundary) begin
        shadow <= bus.load ? bus.value : pend ? pend_reg : shadow;
        pend <= 1'b0;
      end else if (bus.load) begin
        pend_reg <= bus.value;
        pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table, directed and randomized checks against a frame-level reference model
module tb_seg_scan_ctrl;
  localparam int NDIG = 4, DIV = 8, BLANK = 2, FRAME = NDIG * DIV;
  logic clk = 1'b0, rst_n = 1'b0;
  int tests = 0, fails = 0;
  seg_scan_if #(.NDIG(NDIG)) bus();
  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110,
    7'b0111101, 7'b1001111, 7'b1000111};
  int n;
  logic [15:0] sh_m, pv_m;
  logic pend_m;
  logic ld_at [1024];
  logic [15:0] ld_v [1024];
  logic [6:0] o_seg [1024];
  logic [3:0] o_en [1024];
  logic o_pend [1024];
  logic o_fd [1024];
  typedef struct { int n; logic [6:0] seg; logic [3:0] en; logic pend; logic fd; } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (n=%0d)", nm, act, exp, n);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 1024; i++) begin
      ld_at[i] = 1'b0;
      ld_v[i] = '0;
    end
  endtask

  task automatic do_reset(input int k);
    rst_n = 1'b0;
    bus.load = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
      chk("reset_out", {21'd0, bus.seg, bus.dig_en, bus.pending, bus.frame_done}, 32'd0);
    end
    n = 0;
    sh_m = '0;
    pv_m = '0;
    pend_m = 1'b0;
    rst_n = 1'b1;
    clear_sched();
  endtask

  task automatic run(input int cycles, input int lzmode);
    int c, d;
    logic vis, lz;
    logic [3:0] nb;
    logic [6:0] es;
    logic [3:0] ee;
    for (int i = 0; i < cycles; i++) begin
      lz = lzmode == 2 ? 1'($urandom) : lzmode[0];
      bus.load = ld_at[i];
      bus.value = ld_v[i];
      bus.lz_blank = lz;
      @(negedge clk);
      c = n % DIV;
      d = (n / DIV) % NDIG;
      nb = 4'(sh_m >> (4 * d));
      vis = c >= BLANK && !(lz && d > 0 && (sh_m >> (4 * d)) == 16'd0);
      es = vis ? pat[nb] : 7'd0;
      ee = vis ? 4'(1 << d) : 4'd0;
      o_seg[i] = bus.seg;
      o_en[i] = bus.dig_en;
      o_pend[i] = bus.pending;
      o_fd[i] = bus.frame_done;
      chk("model", {19'd0, bus.seg, bus.dig_en, bus.pending, bus.frame_done},
          {19'd0, es, ee, pend_m, 1'(n % FRAME == FRAME - 1)});
      @(posedge clk);
      if (n % FRAME == FRAME - 1) begin
        sh_m = ld_at[i] ? ld_v[i] : pend_m ? pv_m : sh_m;
        pend_m = 1'b0;
      end else if (ld_at[i]) begin
        pv_m = ld_v[i];
        pend_m = 1'b1;
      end
      n++;
      #1;
    end
    bus.load = 1'b0;
  endtask

  initial begin
    logic [3:0] acc;
    logic hit;
    bus.load = 1'b0;
    bus.value = '0;
    bus.lz_blank = 1'b0;
    n = 0;
    tbl = '{'{0, 7'b0000000, 4'b0000, 0, 0}, '{1, 7'b0000000, 4'b0000, 0, 0},
            '{2, 7'b1111110, 4'b0001, 0, 0}, '{5, 7'b1111110, 4'b0001, 0, 0},
            '{6, 7'b1111110, 4'b0001, 1, 0}, '{7, 7'b1111110, 4'b0001, 1, 0},
            '{10, 7'b1111110, 4'b0010, 1, 0}, '{31, 7'b1111110, 4'b1000, 1, 1},
            '{32, 7'b0000000, 4'b0000, 0, 0}, '{34, 7'b1000111, 4'b0001, 0, 0},
            '{42, 7'b1111001, 4'b0010, 0, 0}, '{50, 7'b1110111, 4'b0100, 0, 0},
            '{58, 7'b0110000, 4'b1000, 0, 0}, '{63, 7'b0110000, 4'b1000, 0, 1}};
    do_reset(3);
    ld_at[5] = 1'b1;
    ld_v[5] = 16'h1A3F;
    run(64, 0);
    foreach (tbl[i])
      chk($sformatf("tbl_n%0d", tbl[i].n), {19'd0, o_seg[tbl[i].n], o_en[tbl[i].n], o_pend[tbl[i].n], o_fd[tbl[i].n]},
          {19'd0, tbl[i].seg, tbl[i].en, tbl[i].pend, tbl[i].fd});
    do_reset(1);
    ld_at[0] = 1'b1;
    ld_v[0] = 16'h0070;
    run(64, 1);
    acc = '0;
    for (int i = 0; i < 64; i++) acc |= o_en[i];
    chk("lz_0070_en_or", {28'd0, acc}, 32'b0011);
    chk("lz_0070_d1", {21'd0, o_seg[42], o_en[42]}, {21'd0, 7'b1110000, 4'b0010});
    chk("lz_0070_d0", {21'd0, o_seg[34], o_en[34]}, {21'd0, 7'b1111110, 4'b0001});
    do_reset(1);
    run(32, 1);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= o_en[i];
    chk("lz_0000_en_or", {28'd0, acc}, 32'b0001);
    do_reset(1);
    ld_at[3] = 1'b1;
    ld_v[3] = 16'h1111;
    ld_at[10] = 1'b1;
    ld_v[10] = 16'h2222;
    run(64, 0);
    hit = 1'b0;
    for (int i = 0; i < 64; i++) hit |= o_seg[i] == 7'b0110000;
    chk("two_loads_no_1", {31'd0, hit}, 32'd0);
    for (int k = 0; k < NDIG; k++) chk("two_loads_2222", {25'd0, o_seg[34 + 8 * k]}, {25'd0, 7'b1101101});
    do_reset(1);
    ld_at[31] = 1'b1;
    ld_v[31] = 16'h5555;
    run(64, 0);
    hit = 1'b0;
    for (int i = 0; i < 64; i++) hit |= o_pend[i];
    chk("bnd_load_pend", {31'd0, hit}, 32'd0);
    for (int k = 0; k < NDIG; k++) chk("bnd_load_5555", {25'd0, o_seg[34 + 8 * k]}, {25'd0, 7'b1011011});
    do_reset(1);
    ld_at[18] = 1'b1;
    ld_v[18] = 16'h8888;
    run(21, 0);
    chk("midrst_pending_before", {31'd0, bus.pending}, 32'd1);
    do_reset(1);
    run(40, 0);
    chk("midrst_restart", {21'd0, o_seg[2], o_en[2]}, {21'd0, 7'b1111110, 4'b0001});
    chk("midrst_discard", {21'd0, o_seg[34], o_en[34]}, {21'd0, 7'b1111110, 4'b0001});
    do_reset(1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 300; i++) begin
        ld_at[i] = $urandom_range(0, 5) == 0;
        ld_v[i] = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      end
      run(300, p);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
